// File: rtl/bless_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bless_pkg
// Purpose  : Shared constants and types for the bufferless deflection router
//            PE injection path (flit width, port count, slot index type and
//            injection FSM state encoding).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package bless_pkg;

  localparam int BLESS_FLIT_W   = 32;
  localparam int BLESS_NUM_PORT = 4;
  localparam int BLESS_SLOT_W   = $clog2(BLESS_NUM_PORT);

  typedef logic [BLESS_SLOT_W-1:0] slot_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HEAD    = 2'd1,
    STARVED = 2'd2
  } inj_state_t;

endpackage
`default_nettype wire

// File: rtl/bless_inj_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bless_inj_fifo
// Purpose  : DEPTH x WIDTH injection FIFO with wrap-around pointers and an
//            occupancy count. The caller guarantees push only when not full
//            and pop only when not empty.
// Ports    : clk, reset (async, active-low), push, pop, push_data,
//            head (current head entry), count (occupancy 0..DEPTH)
// Revision : 1.0  initial release
// ============================================================================
module bless_inj_fifo
  import bless_pkg::*;
#(
  parameter int WIDTH = BLESS_FLIT_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset: the count gates every read, so stale data is
  // never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/bless_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bless_inject_ctrl
// Purpose  : PE injection controller for a bufferless deflection router.
//            Buffers PE flits, injects the head flit into the lowest-indexed
//            empty router input slot, and optionally flags starvation.
// Config   : BLESS_STARVE_MON_EN - when defined, enables the blocked-cycle
//            counter, the STARVED state and the starved output. When
//            undefined, starved is tied to 0.
// Ports    : clk, reset (async, active-low)
//            pe_valid, pe_flit, pe_ready      - PE side handshake
//            in_valid                          - occupied network slots
//            inj_valid, inj_flit, inj_slot     - registered injection
//            fifo_count                        - FIFO occupancy
//            starved                           - head blocked too long
// Revision : 1.0  initial release
// ============================================================================
module bless_inject_ctrl
  import bless_pkg::*;
#(
  parameter int WIDTH        = BLESS_FLIT_W,
  parameter int DEPTH        = 4,
  parameter int NUM_PORT     = BLESS_NUM_PORT,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pe_valid,
  input  logic [WIDTH-1:0]            pe_flit,
  output logic                        pe_ready,
  input  logic [NUM_PORT-1:0]         in_valid,
  output logic                        inj_valid,
  output logic [WIDTH-1:0]            inj_flit,
  output logic [$clog2(NUM_PORT)-1:0] inj_slot,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        starved
);

  localparam int                SLOT_W     = $clog2(NUM_PORT);
  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_COUNT  = CNT_W'(1);

  logic              push;
  logic              pop;
  logic              free;
  logic              nonempty;
  logic              last;
  logic [SLOT_W-1:0] sel;
  logic [WIDTH-1:0]  head;
  inj_state_t        state;

  // pe_ready derives only from the registered count: a full FIFO refuses a
  // flit even in a cycle where it also pops.
  assign pe_ready = (fifo_count != FULL_COUNT);
  assign nonempty = (fifo_count != '0);
  assign last     = (fifo_count == ONE_COUNT);
  assign free     = ~&in_valid;
  assign push     = pe_valid & pe_ready;
  assign pop      = nonempty & free;

  // Lowest-indexed empty slot; scanning downward lets the lowest index win.
  always_comb begin
    sel = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (!in_valid[i]) begin
        sel = SLOT_W'(i);
      end
    end
  end

  bless_inj_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pe_flit),
    .head      (head),
    .count     (fifo_count)
  );

  // Registering the injection aligns it with the network flits the router
  // captures from the same cycle's input slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_valid <= 1'b0;
      inj_flit  <= '0;
      inj_slot  <= '0;
    end else begin
      inj_valid <= pop;
      if (pop) begin
        inj_flit <= head;
        inj_slot <= sel;
      end
    end
  end

`ifdef BLESS_STARVE_MON_EN
  localparam int               BLK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BLK_W-1:0] LIMIT = BLK_W'(STARVE_LIMIT);

  logic [BLK_W-1:0] blk_cnt;
  logic             starved_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      blk_cnt   <= '0;
      starved_q <= 1'b0;
    end else begin
      // pop and blocked are mutually exclusive (pop needs a free slot).
      if (pop) begin
        blk_cnt <= '0;
      end else if (nonempty && !free && (blk_cnt != LIMIT)) begin
        blk_cnt <= blk_cnt + 1'b1;
      end

      case (state)
        EMPTY: begin
          if (push) begin
            state <= HEAD;
          end
        end
        HEAD: begin
          if (pop && last && !push) begin
            state <= EMPTY;
          end else if (!free && ((blk_cnt + 1'b1) == LIMIT)) begin
            state     <= STARVED;
            starved_q <= 1'b1;
          end
        end
        STARVED: begin
          if (pop) begin
            starved_q <= 1'b0;
            state     <= (last && !push) ? EMPTY : HEAD;
          end
        end
        default: begin
          state     <= EMPTY;
          starved_q <= 1'b0;
        end
      endcase
    end
  end

  assign starved = starved_q;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state <= HEAD;
          end
        end
        HEAD: begin
          if (pop && last && !push) begin
            state <= EMPTY;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  assign starved = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bless_inject_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bless_inject_ctrl
// Purpose  : Self-checking bench for bless_inject_ctrl. A driver applies
//            directed and random stimulus while a queue-based reference model
//            predicts injections into a scoreboard; a monitor compares them.
// Revision : 1.0  initial release
// ============================================================================
module tb_bless_inject_ctrl;

  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic        clk;
  logic        reset;
  logic        pe_valid;
  logic [31:0] pe_flit;
  logic        pe_ready;
  logic [3:0]  in_valid;
  logic        inj_valid;
  logic [31:0] inj_flit;
  logic [1:0]  inj_slot;
  logic [2:0]  fifo_count;
  logic        starved;

  bless_inject_ctrl #(
    .WIDTH        (32),
    .DEPTH        (DEPTH),
    .NUM_PORT     (4),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pe_valid   (pe_valid),
    .pe_flit    (pe_flit),
    .pe_ready   (pe_ready),
    .in_valid   (in_valid),
    .inj_valid  (inj_valid),
    .inj_flit   (inj_flit),
    .inj_slot   (inj_slot),
    .fifo_count (fifo_count),
    .starved    (starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    logic [1:0]  slot;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  int          blk;
  int          edge_n;
  int          tests;
  int          errors;
  bit          mon_en;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_starved();
`ifdef BLESS_STARVE_MON_EN
    return (blk >= LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: check the registered state against the model, drive
  // inputs, and advance the model by what the next edge must do.
  task automatic cycle(input bit pv, input logic [31:0] pf, input logic [3:0] iv);
    bit       free;
    bit       do_pop;
    bit       do_push;
    bit [1:0] sel;
    @(posedge clk);
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(model_q.size()));
    chk("pe_ready", 32'(pe_ready), 32'(model_q.size() != DEPTH));
    chk("starved", 32'(starved), 32'(exp_starved()));
    pe_valid = pv;
    pe_flit  = pf;
    in_valid = iv;
    free = (iv != 4'hF);
    sel  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!iv[i]) sel = 2'(i);
    end
    do_pop  = free && (model_q.size() > 0);
    do_push = pv && (model_q.size() < DEPTH);
    if (do_pop) begin
      exp_q.push_back('{flit: model_q[0], slot: sel, due: edge_n + 1});
      void'(model_q.pop_front());
      blk = 0;
    end else if (model_q.size() > 0) begin
      blk = (blk + 1 > LIMIT) ? LIMIT : blk + 1;
    end
    if (do_push) model_q.push_back(pf);
  endtask

  // Monitor: every cycle, either the oldest expected injection is due and
  // must be presented, or inj_valid must be low.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].due < edge_n) begin
          tests++;
          errors++;
          $display("FAIL missed_inj: got none, expected flit 0x%0h", exp_q[0].flit);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
          chk("inj_valid", 32'(inj_valid), 32'd1);
          chk("inj_flit", inj_flit, exp_q[0].flit);
          chk("inj_slot", 32'(inj_slot), 32'(exp_q[0].slot));
          void'(exp_q.pop_front());
        end else begin
          chk("inj_valid_idle", 32'(inj_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    tests    = 0;
    errors   = 0;
    blk      = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    pe_valid = 1'b1;
    pe_flit  = 32'hDEAD_BEEF;
    in_valid = 4'h0;

    // Reset held with an offer pending.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pe_ready", 32'(pe_ready), 32'd1);
    chk("rst_inj_valid", 32'(inj_valid), 32'd0);
    chk("rst_inj_flit", inj_flit, 32'd0);
    chk("rst_inj_slot", 32'(inj_slot), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_starved", 32'(starved), 32'd0);
    pe_valid = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single flit blocked three cycles, then slots 0 and 2 busy -> slot 1.
    cycle(1'b1, 32'hA5A5_0001, 4'b1111);
    repeat (3) cycle(1'b0, 32'h0, 4'b1111);
    cycle(1'b0, 32'h0, 4'b0101);
    cycle(1'b0, 32'h0, 4'b0000);

    // Fill, overflow offer, then drain in order into slot 0.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 4'b1111);
    cycle(1'b1, 32'h5, 4'b1111);
    repeat (4) cycle(1'b0, 32'h0, 4'b0000);
    cycle(1'b0, 32'h0, 4'b0000);

    // Full FIFO with pop and offer together, then push+pop at count 2.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(i), 4'b1111);
    cycle(1'b1, 32'h16, 4'b0000);
    cycle(1'b0, 32'h0, 4'b0000);
    cycle(1'b1, 32'h17, 4'b0000);
    repeat (4) cycle(1'b0, 32'h0, 4'b0000);

    // Starvation: head blocked past the limit, then slot 3 frees.
    cycle(1'b1, 32'h55, 4'b1111);
    repeat (LIMIT + 2) cycle(1'b0, 32'h0, 4'b1111);
    cycle(1'b0, 32'h0, 4'b0111);
    cycle(1'b0, 32'h0, 4'b0000);

    // Randomized traffic with phases of varying congestion.
    for (int p = 0; p < 12; p++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int c = 0; c < 32; c++) begin
        logic [3:0] iv;
        case (mode)
          0:       iv = 4'($urandom);
          1:       iv = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
          default: iv = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        endcase
        cycle(($urandom_range(0, 2) != 0), $urandom, iv);
      end
    end
    repeat (8) cycle(1'b0, 32'h0, 4'b0000);

    // Asynchronous reset with three flits queued and an injection live.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC0 + 32'(i), 4'b1111);
    cycle(1'b0, 32'h0, 4'b0000);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    model_q.delete();
    blk = 0;
    #1;
    chk("async_fifo_count", 32'(fifo_count), 32'd0);
    chk("async_inj_valid", 32'(inj_valid), 32'd0);
    chk("async_pe_ready", 32'(pe_ready), 32'd1);
    chk("async_starved", 32'(starved), 32'd0);
    in_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) cycle(1'b0, 32'h0, 4'b0000);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bless_inject_ctrl.md
# bless_inject_ctrl

Injection controller for the local processing element (PE) port of the bufferless deflection router. It buffers flits offered by the PE in a small FIFO and watches which router input slots are empty this cycle. When a slot is free, it schedules the head flit into the lowest-indexed free slot, registered so it arrives in the same pipeline stage as the flits captured from the network ports. A starvation monitor flags a head flit that has been blocked too long.

## Interface
- WIDTH, 32: flit width in bits
- DEPTH, 4: injection FIFO entries (power of two, ≥2)
- NUM_PORT, 4: router input slots (network ports)
- STARVE_LIMIT, 16: consecutive blocked cycles before `starved` asserts (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pe_valid  in  1  PE offers `pe_flit`
- pe_flit  in  WIDTH  flit from PE
- pe_ready  out  1  FIFO can accept a flit (registered)
- in_valid  in  NUM_PORT  bit i = network slot i carries a valid flit this cycle
- inj_valid  out  1  injected flit valid (registered)
- inj_flit  out  WIDTH  injected flit (registered)
- inj_slot  out  clog2(NUM_PORT)  slot index the injected flit occupies (registered)
- fifo_count  out  clog2(DEPTH)+1  occupancy (registered)
- starved  out  1  head blocked ≥ STARVE_LIMIT cycles (registered)

## Operation
- Push: `pe_valid && pe_ready`. `pe_ready = (fifo_count != DEPTH)`, computed from registered state; no same-cycle pop credit when full.
- Free slot: `free = ~&in_valid`. `sel` is the lowest index i with `in_valid[i] == 0`.
- Pop: FIFO non-empty && free. The head flit and `sel` register into `inj_flit`/`inj_slot`, and `inj_valid` is set to 1.
- When there is no pop, `inj_valid` is 0 on the next cycle. `inj_flit` and `inj_slot` hold their previous values.
- Push and pop in the same cycle leave `fifo_count` unchanged. Pointers wrap modulo DEPTH.
- FSM, state in a register:
  - EMPTY: count = 0. Push goes to HEAD.
  - HEAD: non-empty, counter below limit.
    - Pop that empties the FIFO with no push goes to EMPTY.
    - Blocked cycle with counter+1 == STARVE_LIMIT goes to STARVED.
  - STARVED: non-empty, `starved` = 1. Pop goes to HEAD, or to EMPTY if the FIFO empties.
- Blocked counter:
  - Increments each cycle the FIFO is non-empty and `free` = 0.
  - Saturates at STARVE_LIMIT.
  - Clears on every pop.
- The block does not reorder flits; strict FIFO order.

## Timing
- Reset values: `pe_ready` = 1, `inj_valid` = 0, `inj_flit` = 0, `inj_slot` = 0, `fifo_count` = 0, `starved` = 0. FIFO pointers, counter and FSM state (EMPTY) also reset.
- Reset asserted mid-operation: all buffered flits are discarded immediately (asynchronous). Outputs return to reset values without waiting for a clock edge.
- Latency:
  - Push at edge t makes the head visible at t+1.
  - With a free slot in cycle t+1, `inj_valid` = 1 after edge t+2.
  - Minimum PE-to-injection latency is 2 cycles. There is no bypass.
- `in_valid` sampled in cycle t is aligned so that `inj_*` after edge t+1 coincides with the router's registered network flits from cycle t.
- Throughput: 1 flit/cycle when a slot is free every cycle.
- `starved` rises on the edge where the counter reaches STARVE_LIMIT and falls on the edge of the pop.

## Configuration
- `BLESS_STARVE_MON_EN` defined: blocked counter, STARVED state and `starved` are implemented as above.
- `BLESS_STARVE_MON_EN` undefined: counter and STARVED state are removed. `starved` is tied to 0, and the FSM has only EMPTY and HEAD. All other behaviour is identical.

## Structure
- Shared package `bless_pkg`:
  - flit width constant
  - NUM_PORT constant
  - slot-index typedef
  - FSM state enum (EMPTY, HEAD, STARVED)
- Sub-module `bless_inj_fifo`: DEPTH×WIDTH storage, wrap-around pointers, count, push/pop.
- The top level contains the free-slot priority encoder, the output registers and the FSM.

## Test plan
- Reset with `pe_valid` = 1: outputs hold reset values. After release, `pe_ready` = 1 and `fifo_count` = 0.
- Push 0xA5A5_0001 at edge 1 with `in_valid` = 4'b1111 for 3 cycles, then 4'b0101: `inj_valid` = 1 with flit 0xA5A5_0001 and `inj_slot` = 1, one edge after `in_valid` drops.
- Push 4 flits 0x1–0x4 with `in_valid` = 4'b1111:
  - `fifo_count` = 4 and `pe_ready` = 0.
  - A 5th offer (0x5) is not accepted.
  - Then `in_valid` = 4'b0000: flits exit 0x1, 0x2, 0x3, 0x4 on consecutive cycles, all with `inj_slot` = 0.
- Full FIFO: pop and `pe_valid` in the same cycle leave count at 3 with no push. In a count = 2 cycle with push and pop together, count stays 2.
- Macro on, STARVE_LIMIT = 16, head held with `in_valid` = 4'b1111 for 16 cycles: `starved` = 1 after the 16th blocked edge. Freeing slot 3 gives inj to slot 3 and `starved` = 0 on the same edge.
- Assert `reset` with 3 flits queued: `fifo_count` = 0 and `inj_valid` = 0 immediately. After release, no stale flit is injected when `in_valid` = 0.
